tilelink_ad_responder: RTL

- Parametrised TileLink-UL/UH A/D responder that stands in for memory behind a core's master port in formal and simulation harnesses.
- Accepts A-channel requests into an in-order outstanding queue of configurable depth, then returns D-channel responses:
  - Get: multi-beat AccessAckData.
  - PutFullData/PutPartialData: AccessAck after all A beats.
  - Other opcodes: error responses.
- Read data is supplied externally each D beat (free variable in formal, driven by the bench in simulation).

---
 rtl/tl_ad_pkg.sv | 36 +++
 rtl/tilelink_ad_responder_if.sv | 45 ++++
 rtl/tl_ad_req_fifo.sv | 44 ++++
 rtl/tilelink_ad_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tl_ad_pkg.sv
// Shared TileLink A/D opcodes, the queued request record and the beat-count helper
// for the tilelink_ad_responder block.
package tl_ad_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  // Record fields are sized for the widest configuration; users truncate on read.
  localparam int unsigned REQ_SIZE_W = 8;
  localparam int unsigned REQ_SRC_W  = 16;
  localparam int unsigned REQ_LO_W   = 8;

  typedef struct packed {
    logic [2:0]            opcode;
    logic [REQ_SIZE_W-1:0] size;
    logic [REQ_SRC_W-1:0]  source;
    logic [REQ_LO_W-1:0]   addr_lo;
    logic                  error;
  } req_t;

  function automatic int unsigned beats(input int unsigned size, input int unsigned data_w);
    int unsigned lg;
    lg = $clog2(data_w / 8);
    if (size > lg) return 32'd1 << (size - lg);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tilelink_ad_responder_if.sv
// TileLink-UL/UH A and D channel bundle; master drives A, slave (the responder) drives D.
interface tilelink_ad_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 1,
  parameter int unsigned SIZE_W = 4
);
  localparam int unsigned LO_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic [DATA_W-1:0] a_data;

  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic [LO_W-1:0]   d_addr_lo;
  logic [DATA_W-1:0] d_data;
  logic              d_error;

  modport master (
    input  a_ready,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error
  );

  modport slave (
    output a_ready,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error
  );

endinterface

// File: rtl/tl_ad_req_fifo.sv
// In-order request queue; a pop and push in the same cycle while full reuses the freed slot.
module tl_ad_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Caller guarantees no push while full without a same-cycle pop.
  always_ff @(posedge clock) begin
    if (push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/tilelink_ad_responder.sv
// TileLink A/D memory stand-in: queues A requests in order and answers on D.
// Define TL_AD_RANDOM_STALL_EN to let stall_a / stall_d throttle the channels.
module tilelink_ad_responder
  import tl_ad_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SRC_W    = 1,
  parameter int unsigned SIZE_W   = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_SIZE = 6
) (
  input logic                  clock,
  input logic                  reset_n,
  tilelink_ad_responder_if.slave bus,
  input logic [DATA_W-1:0]     rdata,
  input logic                  stall_a,
  input logic                  stall_d
);
  localparam int unsigned LO_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

  logic              ready_q;
  logic [31:0]       a_cnt_q, d_cnt_q;
  logic [2:0]        cap_opcode_q;
  logic [SIZE_W-1:0] cap_size_q;
  logic [SRC_W-1:0]  cap_source_q;
  logic [LO_W-1:0]   cap_lo_q;

  logic              a_first, a_last, a_fire, is_put, push, pop, full, empty;
  logic [2:0]        cur_opcode;
  logic [SIZE_W-1:0] cur_size;
  logic [SRC_W-1:0]  cur_source;
  logic [LO_W-1:0]   cur_lo, addr_lo;
  req_t              push_req, head;
  logic [31:0]       d_beats;
  logic              d_valid, d_fire, d_last, a_stall;

  // Later beats of a Put burst reuse the fields captured on the first beat.
  assign addr_lo    = (DATA_W > 8) ? bus.a_address[LO_W-1:0] : '0;
  assign a_first    = (a_cnt_q == '0);
  assign cur_opcode = a_first ? bus.a_opcode : cap_opcode_q;
  assign cur_size   = a_first ? bus.a_size : cap_size_q;
  assign cur_source = a_first ? bus.a_source : cap_source_q;
  assign cur_lo     = a_first ? addr_lo : cap_lo_q;
  assign is_put     = (cur_opcode == A_PUT_FULL) || (cur_opcode == A_PUT_PARTIAL);
  assign a_last     = !is_put || (a_cnt_q == beats(32'(cur_size), DATA_W) - 32'd1);
  assign a_fire     = bus.a_valid && bus.a_ready;
  assign push       = a_fire && a_last;

  always_comb begin
    push_req         = '0;
    push_req.size    = REQ_SIZE_W'(cur_size);
    push_req.source  = REQ_SRC_W'(cur_source);
    push_req.addr_lo = REQ_LO_W'(cur_lo);
    push_req.error   = (32'(cur_size) > MAX_SIZE);
    case (cur_opcode)
      A_GET:                     push_req.opcode = D_ACCESS_ACK_DATA;
      A_PUT_FULL, A_PUT_PARTIAL: push_req.opcode = D_ACCESS_ACK;
      A_ARITH, A_LOGIC: begin
        push_req.opcode = D_ACCESS_ACK_DATA;
        push_req.error  = 1'b1;
      end
      A_INTENT: begin
        push_req.opcode = D_HINT_ACK;
        push_req.error  = 1'b1;
      end
      default: begin
        push_req.opcode = D_ACCESS_ACK;
        push_req.error  = 1'b1;
      end
    endcase
  end

  tl_ad_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_req),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );

  assign d_beats = (head.opcode == D_ACCESS_ACK_DATA) ? beats(32'(head.size), DATA_W) : 32'd1;
  assign d_last  = (d_cnt_q == d_beats - 32'd1);
  assign d_fire  = d_valid && bus.d_ready;
  assign pop     = d_fire && d_last;

`ifdef TL_AD_RANDOM_STALL_EN
  // An offered beat must stay up until taken, so stall_d only gates a fresh offer.
  logic offered_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) offered_q <= 1'b0;
    else          offered_q <= d_valid && !bus.d_ready;
  end
  assign d_valid = !empty && (!stall_d || offered_q);
  assign a_stall = stall_a;
`else
  logic unused_stall;
  assign unused_stall = stall_a ^ stall_d;
  assign d_valid = !empty;
  assign a_stall = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q      <= 1'b0;
      a_cnt_q      <= '0;
      d_cnt_q      <= '0;
      cap_opcode_q <= '0;
      cap_size_q   <= '0;
      cap_source_q <= '0;
      cap_lo_q     <= '0;
    end else begin
      ready_q <= 1'b1;
      if (a_fire) begin
        a_cnt_q <= a_last ? '0 : a_cnt_q + 32'd1;
        if (a_first) begin
          cap_opcode_q <= bus.a_opcode;
          cap_size_q   <= bus.a_size;
          cap_source_q <= bus.a_source;
          cap_lo_q     <= addr_lo;
        end
      end
      if (d_fire) d_cnt_q <= d_last ? '0 : d_cnt_q + 32'd1;
    end
  end

  assign bus.a_ready   = (!full || pop) && ready_q && !a_stall;
  assign bus.d_valid   = d_valid;
  assign bus.d_opcode  = d_valid ? head.opcode : '0;
  assign bus.d_param   = '0;
  assign bus.d_size    = d_valid ? head.size[SIZE_W-1:0] : '0;
  assign bus.d_source  = d_valid ? head.source[SRC_W-1:0] : '0;
  assign bus.d_sink    = 1'b0;
  assign bus.d_addr_lo = d_valid ? head.addr_lo[LO_W-1:0] : '0;
  assign bus.d_error   = d_valid && head.error;
  assign bus.d_data    = (d_valid && head.opcode == D_ACCESS_ACK_DATA) ? rdata : '0;

  logic unused_bits;
  assign unused_bits = ^{bus.a_param, bus.a_mask, bus.a_data, bus.a_address, head};

endmodule
